mac_sequencer: RTL and testbench

Parametrised control sequencer for the multiply-accumulate datapath. Walks a tap/channel select across up to NTAPS inputs, drives the accumulator clear/enable strobes, and issues an output-register load plus done pulse per frame. Supports runtime frame length, stall, and continuous (back-to-back) framing. Sits between the top-level control and the mux/accumulator/output-register datapath.

---
 rtl/seq_pkg.sv | 14 +
 rtl/tap_counter.sv | 30 +++
 rtl/mac_sequencer.sv | 105 ++++++++++
 tb/tb_mac_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the multiply-accumulate control sequencer.
package seq_pkg;

    // Sequencer states; encodings are fixed so state can be probed externally.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LOAD = 2'b10
    } statetype;

    // Default width of the completed-frame counter.
    localparam int FCW_DEFAULT = 8;

endpackage

// File: rtl/tap_counter.sv
// Tap index register with synchronous clear, count enable and a terminal
// compare against the latched frame length.
module tap_counter #(
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    input  logic [SELW-1:0] len,
    output logic [SELW-1:0] idx,
    output logic            last
);

    // Index register: clear has priority over increment.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!reset) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= idx + SELW'(1);
        end
    end

    // Terminal tap reached when the index matches the frame length.
    assign last = (idx == len);

endmodule

// File: rtl/mac_sequencer.sv
// Control sequencer for the MAC datapath: walks the tap select over a frame,
// strobes the accumulator, and loads the output register once per frame.
module mac_sequencer
    import seq_pkg::*;
#(
    parameter int NTAPS = 4,
    parameter int SELW  = $clog2(NTAPS),
    parameter int FCW   = FCW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            cont,
    input  logic [SELW-1:0] len_m1,
    input  logic            hold,
    output logic [SELW-1:0] mux_sel,
    output logic            accum_en,
    output logic            clear_accum,
    output logic            load_out,
    output logic            done,
    output logic            busy,
    output logic [FCW-1:0]  frame_cnt
);

    // Largest legal last-tap index; always representable in SELW bits.
    localparam logic [SELW-1:0] MAX_LEN = SELW'(NTAPS - 1);

    statetype        state;
    statetype        state_nxt;
    logic [SELW-1:0] len_q;
    logic [SELW-1:0] len_eff;
    logic [SELW-1:0] idx;
    logic            last;
    logic            cnt_clr;
    logic            cnt_en;

    // Requested length, clamped to the number of physical taps.
    assign len_eff = (len_m1 > MAX_LEN) ? MAX_LEN : len_m1;

    // Index is held at zero outside RUN and advances on non-stalled RUN cycles.
    assign cnt_clr = (state != RUN);
    assign cnt_en  = (state == RUN) && !hold && !last;

    tap_counter #(
        .SELW (SELW)
    ) u_tap_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .len   (len_q),
        .idx   (idx),
        .last  (last)
    );

    // Next-state decode.
    always_comb begin
        // NOTE: assigning a default first keeps this purely combinational (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (!hold && last) state_nxt = LOAD;
            LOAD:    state_nxt = cont ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame length is captured only when a start is honoured in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q <= '0;
        end else if ((state == IDLE) && start) begin
            len_q <= len_eff;
        end
    end

    // Completed-frame counter, bumped once per LOAD and wrapping naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (state == LOAD) begin
            frame_cnt <= frame_cnt + FCW'(1);
        end
    end

    // Moore outputs; accumulator strobes are additionally gated by hold.
    always_comb begin
        mux_sel     = (state == IDLE) ? '0 : idx;
        busy        = (state == RUN) || (state == LOAD);
        load_out    = (state == LOAD);
        done        = (state == LOAD);
        accum_en    = (state == RUN) && !hold;
        clear_accum = (state == RUN) && !hold && (idx == '0);
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed-vector bench for mac_sequencer. A second instance with NTAPS=3 and
// FCW=2 shares the stimulus to exercise length clamping and counter wrap.
module tb_mac_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       cont;
    logic [1:0] len_m1;
    logic       hold;

    logic [1:0] mux_sel;
    logic       accum_en, clear_accum, load_out, done, busy;
    logic [7:0] frame_cnt;

    logic [1:0] mux_sel2;
    logic       accum_en2, clear_accum2, load_out2, done2, busy2;
    logic [1:0] frame_cnt2;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [6:0] FULL  = 7'h7F;
    localparam logic [6:0] NOMUX = 7'h1F;

    mac_sequencer #(.NTAPS(4), .FCW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cont        (cont),
        .len_m1      (len_m1),
        .hold        (hold),
        .mux_sel     (mux_sel),
        .accum_en    (accum_en),
        .clear_accum (clear_accum),
        .load_out    (load_out),
        .done        (done),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    mac_sequencer #(.NTAPS(3), .FCW(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cont        (cont),
        .len_m1      (len_m1),
        .hold        (hold),
        .mux_sel     (mux_sel2),
        .accum_en    (accum_en2),
        .clear_accum (clear_accum2),
        .load_out    (load_out2),
        .done        (done2),
        .busy        (busy2),
        .frame_cnt   (frame_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {mux_sel, accum_en, clear_accum, load_out, done, busy}.
    function automatic logic [6:0] obs();
        return {mux_sel, accum_en, clear_accum, load_out, done, busy};
    endfunction

    function automatic logic [6:0] obs2();
        return {mux_sel2, accum_en2, clear_accum2, load_out2, done2, busy2};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        start  = 1'b0;
        cont   = 1'b0;
        hold   = 1'b0;
        len_m1 = 2'd0;
        reset  = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        start  = 1'b0;
        cont   = 1'b0;
        hold   = 1'b0;
        len_m1 = 2'd0;
        reset  = 1'b0;
        #3;
        n_vec++;
        if (obs() !== 7'd0 || frame_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_asserted: outputs %b cnt %0d, want 0000000 cnt 0", obs(), frame_cnt);
        end
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (obs() !== 7'd0 || frame_cnt !== 8'd0 || obs2() !== 7'd0 || frame_cnt2 !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_released: outputs %b/%b cnt %0d/%0d, want zeros", obs(), obs2(), frame_cnt, frame_cnt2);
        end
        next_cycle();
    endtask

    // len_m1=3: taps 0..3, clear on first tap only, LOAD in cycle 5, idle in 6.
    task automatic test_basic();
        logic       st [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [6:0] ev [7] = '{7'b00_00000, 7'b00_11001, 7'b01_10001, 7'b10_10001,
                               7'b11_10001, 7'b00_00111, 7'b00_00000};
        logic [6:0] mk [7] = '{FULL, FULL, FULL, FULL, FULL, NOMUX, FULL};
        len_m1 = 2'd3;
        for (int i = 0; i < 7; i++) begin
            start = st[i];
            @(negedge clk);
            n_vec++;
            if ((obs() & mk[i]) !== (ev[i] & mk[i])) begin
                n_bad++;
                $display("FAIL basic cycle %0d: got %b want %b (mask %b)", i, obs(), ev[i], mk[i]);
            end
            next_cycle();
        end
        n_vec++;
        if (frame_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL basic frame_cnt: got %0d want 1", frame_cnt);
        end
    endtask

    // len_m1=0: one RUN cycle with accum_en and clear_accum, done next cycle.
    task automatic test_single_tap();
        logic       st [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [6:0] ev [4] = '{7'b00_00000, 7'b00_11001, 7'b00_00111, 7'b00_00000};
        logic [6:0] mk [4] = '{FULL, FULL, NOMUX, FULL};
        len_m1 = 2'd0;
        for (int i = 0; i < 4; i++) begin
            start = st[i];
            @(negedge clk);
            n_vec++;
            if ((obs() & mk[i]) !== (ev[i] & mk[i])) begin
                n_bad++;
                $display("FAIL single cycle %0d: got %b want %b (mask %b)", i, obs(), ev[i], mk[i]);
            end
            next_cycle();
        end
        n_vec++;
        if (frame_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL single frame_cnt: got %0d want 2", frame_cnt);
        end
    endtask

    // Two hold cycles at mux_sel=2 stretch the frame by two; hold in LOAD is ignored.
    task automatic test_hold();
        logic [1:0] st [9] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [6:0] ev [9] = '{7'b00_00000, 7'b00_11001, 7'b01_10001, 7'b10_00001, 7'b10_00001,
                               7'b10_10001, 7'b11_10001, 7'b00_00111, 7'b00_00000};
        logic [6:0] mk [9] = '{FULL, FULL, FULL, FULL, FULL, FULL, FULL, NOMUX, FULL};
        len_m1 = 2'd3;
        for (int i = 0; i < 9; i++) begin
            {start, hold} = st[i];
            @(negedge clk);
            n_vec++;
            if ((obs() & mk[i]) !== (ev[i] & mk[i])) begin
                n_bad++;
                $display("FAIL hold cycle %0d: got %b want %b (mask %b)", i, obs(), ev[i], mk[i]);
            end
            next_cycle();
        end
        hold = 1'b0;
        n_vec++;
        if (frame_cnt !== 8'd3) begin
            n_bad++;
            $display("FAIL hold frame_cnt: got %0d want 3", frame_cnt);
        end
    endtask

    // Continuous len_m1=1: done every 3 cycles; mid-frame start and len changes ignored.
    task automatic test_back_to_back();
        // {start, cont, len_m1}
        logic [3:0] st [9] = '{4'b1101, 4'b0111, 4'b1111, 4'b1111, 4'b0011,
                               4'b1011, 4'b0011, 4'b0001, 4'b0001};
        logic [6:0] ev [9] = '{7'b00_00000, 7'b00_11001, 7'b01_10001, 7'b00_00111, 7'b00_11001,
                               7'b01_10001, 7'b00_00111, 7'b00_00000, 7'b00_00000};
        logic [6:0] mk [9] = '{FULL, FULL, FULL, NOMUX, FULL, FULL, NOMUX, FULL, FULL};
        for (int i = 0; i < 9; i++) begin
            {start, cont, len_m1} = st[i];
            @(negedge clk);
            n_vec++;
            if ((obs() & mk[i]) !== (ev[i] & mk[i])) begin
                n_bad++;
                $display("FAIL b2b cycle %0d: got %b want %b (mask %b)", i, obs(), ev[i], mk[i]);
            end
            next_cycle();
        end
        {start, cont} = 2'b00;
        n_vec++;
        if (frame_cnt !== 8'd5) begin
            n_bad++;
            $display("FAIL b2b frame_cnt: got %0d want 5", frame_cnt);
        end
    endtask

    // NTAPS=3 instance: len_m1=3 clamps to 2, giving three RUN cycles.
    task automatic test_clamp();
        logic       st [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [6:0] ev [6] = '{7'b00_00000, 7'b00_11001, 7'b01_10001, 7'b10_10001,
                               7'b00_00111, 7'b00_00000};
        logic [6:0] mk [6] = '{FULL, FULL, FULL, FULL, NOMUX, FULL};
        apply_reset();
        len_m1 = 2'd3;
        for (int i = 0; i < 6; i++) begin
            start = st[i];
            @(negedge clk);
            n_vec++;
            if ((obs2() & mk[i]) !== (ev[i] & mk[i])) begin
                n_bad++;
                $display("FAIL clamp cycle %0d: got %b want %b (mask %b)", i, obs2(), ev[i], mk[i]);
            end
            next_cycle();
        end
    endtask

    // FCW=2 instance over five frames: counter reads 1,2,3,0,1.
    task automatic test_wrap();
        logic [1:0] ec [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        len_m1 = 2'd0;
        cont   = 1'b1;
        start  = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int f = 0; f < 5; f++) begin
            next_cycle();
            cont = (f < 4);
            @(negedge clk);
            n_vec++;
            if (done2 !== 1'b1) begin
                n_bad++;
                $display("FAIL wrap done frame %0d: got %b want 1", f, done2);
            end
            next_cycle();
            n_vec++;
            if (frame_cnt2 !== ec[f]) begin
                n_bad++;
                $display("FAIL wrap frame_cnt frame %0d: got %0d want %0d", f, frame_cnt2, ec[f]);
            end
        end
        cont = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy2 !== 1'b0 || frame_cnt !== 8'd5) begin
            n_bad++;
            $display("FAIL wrap end: busy %b cnt8 %0d, want busy 0 cnt8 5", busy2, frame_cnt);
        end
        next_cycle();
    endtask

    // Asynchronous reset in RUN at mux_sel=1 clears outputs at once; no done follows.
    task automatic test_reset_midframe();
        len_m1 = 2'd3;
        start  = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (obs() !== 7'b01_10001) begin
            n_bad++;
            $display("FAIL midreset pre: got %b want 0110001", obs());
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (obs() !== 7'd0 || frame_cnt !== 8'd0 || obs2() !== 7'd0 || frame_cnt2 !== 2'd0) begin
            n_bad++;
            $display("FAIL midreset async: outputs %b/%b cnt %0d/%0d, want zeros", obs(), obs2(), frame_cnt, frame_cnt2);
        end
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++;
            if (obs() !== 7'd0) begin
                n_bad++;
                $display("FAIL midreset idle cycle %0d: got %b want 0000000", i, obs());
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_tap();
        test_hold();
        test_back_to_back();
        test_clamp();
        test_wrap();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
